// File: rtl/ring_slide_ctrl_if.sv
// Bundles the slide-request, router-config, beat-gating and completion signals of ring_slide_ctrl.
// slave is the controller's view; master is the slide unit / router side.
interface ring_slide_ctrl_if #(
    parameter int CntW = 11,
    parameter int IdW  = 2
) ();
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_dir_i;
    logic [CntW-1:0] req_tx_beats_i;
    logic [CntW-1:0] req_rx_beats_i;
    logic            sldu_dir_o;
    logic            sldu_bypass_o;
    logic            sldu_config_valid_o;
    logic            tx_en_o;
    logic            rx_en_o;
    logic            tx_fire_i;
    logic            rx_fire_i;
    logic            done_valid_o;
    logic            done_ready_i;
    logic            err_o;
    logic [IdW-1:0]  cluster_id_o;

    modport slave (
        input  req_valid_i, req_dir_i, req_tx_beats_i, req_rx_beats_i,
        input  tx_fire_i, rx_fire_i, done_ready_i,
        output req_ready_o, sldu_dir_o, sldu_bypass_o, sldu_config_valid_o,
        output tx_en_o, rx_en_o, done_valid_o, err_o, cluster_id_o
    );

    modport master (
        output req_valid_i, req_dir_i, req_tx_beats_i, req_rx_beats_i,
        output tx_fire_i, rx_fire_i, done_ready_i,
        input  req_ready_o, sldu_dir_o, sldu_bypass_o, sldu_config_valid_o,
        input  tx_en_o, rx_en_o, done_valid_o, err_o, cluster_id_o
    );
endinterface

// File: rtl/ring_slide_ctrl.sv
// Per-cluster ring router sequencer: programs direction/bypass, gates and counts TX/RX beats,
// then waits for the router pipeline to drain before signalling completion.
module ring_slide_ctrl #(
    parameter int NrClusters   = 4,
    parameter int ClusterId    = 0,
    parameter int MaxBeats     = 1024,
    parameter int SettleCycles = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    ring_slide_ctrl_if.slave bus
);
    localparam int CntW = $clog2(MaxBeats + 1);
    localparam int SetW = $clog2(SettleCycles + 1);
    localparam int IdW  = $clog2(NrClusters);

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        ACTIVE,
        DRAIN,
        DONE
    } state_e;

    state_e          r_state;
    state_e          w_nextState;
    logic            r_dir;
    logic            r_bypass;
    logic            r_err;
    logic [CntW-1:0] r_txTarget;
    logic [CntW-1:0] r_rxTarget;
    logic [CntW-1:0] r_txCnt;
    logic [CntW-1:0] r_rxCnt;
    logic [SetW-1:0] r_settle;

    logic w_accept;
    logic w_reqReady;
    logic w_configValid;
    logic w_txEn;
    logic w_rxEn;
    logic w_doneValid;
    logic w_txCount;
    logic w_rxCount;
    logic w_txDone;
    logic w_rxDone;
    logic w_loadSettle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Outputs decode only from state and counters, so no input reaches an output combinationally.
    always_comb begin
        w_nextState   = r_state;
        w_reqReady    = 1'b0;
        w_configValid = 1'b0;
        w_txEn        = 1'b0;
        w_rxEn        = 1'b0;
        w_doneValid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_reqReady = 1'b1;
                if (bus.req_valid_i) w_nextState = CONFIG;
            end
            CONFIG: begin
                w_configValid = 1'b1;
                w_nextState   = r_bypass ? DRAIN : ACTIVE;
            end
            ACTIVE: begin
                w_txEn = (r_txCnt != r_txTarget);
                w_rxEn = (r_rxCnt != r_rxTarget);
                if (w_txDone && w_rxDone) w_nextState = DRAIN;
            end
            DRAIN: begin
                if (r_settle <= SetW'(1)) w_nextState = DONE;
            end
            DONE: begin
                w_doneValid = 1'b1;
                if (bus.done_ready_i) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_accept     = w_reqReady & bus.req_valid_i;
    assign w_txCount    = w_txEn & bus.tx_fire_i;
    assign w_rxCount    = w_rxEn & bus.rx_fire_i;
    // A side counts as finished either already at target or on the fire that reaches it.
    assign w_txDone     = (r_txCnt == r_txTarget) || (w_txCount && (r_txCnt + CntW'(1) == r_txTarget));
    assign w_rxDone     = (r_rxCnt == r_rxTarget) || (w_rxCount && (r_rxCnt + CntW'(1) == r_rxTarget));
    assign w_loadSettle = ((r_state == CONFIG) && r_bypass) ||
                          ((r_state == ACTIVE) && w_txDone && w_rxDone);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dir      <= 1'b0;
            r_bypass   <= 1'b1;
            r_err      <= 1'b0;
            r_txTarget <= '0;
            r_rxTarget <= '0;
            r_txCnt    <= '0;
            r_rxCnt    <= '0;
            r_settle   <= '0;
        end else begin
            if (w_accept) begin
                r_dir      <= bus.req_dir_i;
                r_bypass   <= (bus.req_tx_beats_i == '0) && (bus.req_rx_beats_i == '0);
                r_txTarget <= bus.req_tx_beats_i;
                r_rxTarget <= bus.req_rx_beats_i;
                r_txCnt    <= '0;
                r_rxCnt    <= '0;
            end else begin
                if (w_txCount) r_txCnt <= r_txCnt + CntW'(1);
                if (w_rxCount) r_rxCnt <= r_rxCnt + CntW'(1);
            end
            if (w_loadSettle) begin
                r_settle <= SetW'(SettleCycles);
            end else if (r_state == DRAIN) begin
                r_settle <= r_settle - SetW'(1);
            end
            if ((bus.tx_fire_i && !w_txEn) || (bus.rx_fire_i && !w_rxEn)) r_err <= 1'b1;
        end
    end

    assign bus.req_ready_o         = w_reqReady;
    assign bus.sldu_dir_o          = r_dir;
    assign bus.sldu_bypass_o       = r_bypass;
    assign bus.sldu_config_valid_o = w_configValid;
    assign bus.tx_en_o             = w_txEn;
    assign bus.rx_en_o             = w_rxEn;
    assign bus.done_valid_o        = w_doneValid;
    assign bus.err_o               = r_err;
    assign bus.cluster_id_o        = IdW'(ClusterId);
endmodule

// File: tb/tb_ring_slide_ctrl.sv
// Directed bench for ring_slide_ctrl: stimulus pushes expected config strobes and done times
// into queues, and a negedge monitor pops and compares them as the DUT presents them.
module tb_ring_slide_ctrl;
    localparam int NrClusters   = 4;
    localparam int ClusterId    = 2;
    localparam int MaxBeats     = 1024;
    localparam int SettleCycles = 2;
    localparam int CntW         = $clog2(MaxBeats + 1);
    localparam int IdW          = $clog2(NrClusters);

    typedef struct {
        int   cyc;
        logic dir;
        logic byp;
    } cfg_t;

    logic clk_i;
    logic rst_ni;
    int   cycle;
    int   testsRun;
    int   testsFailed;
    logic expErr;
    logic prevDone;
    cfg_t cfgQ[$];
    int   doneQ[$];
    cfg_t mCfg;
    int   mDone;

    ring_slide_ctrl_if #(.CntW(CntW), .IdW(IdW)) bus ();

    ring_slide_ctrl #(
        .NrClusters  (NrClusters),
        .ClusterId   (ClusterId),
        .MaxBeats    (MaxBeats),
        .SettleCycles(SettleCycles)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cycle = 0;
    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every config strobe cycle and every done rising edge must match a queued expectation.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.sldu_config_valid_o) begin
                if (cfgQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedConfig: got strobe at cycle %0d, expected none", cycle);
                end else begin
                    mCfg = cfgQ.pop_front();
                    checkOutput("cfgCycle", cycle, mCfg.cyc);
                    checkOutput("cfgDir", {31'd0, bus.sldu_dir_o}, {31'd0, mCfg.dir});
                    checkOutput("cfgBypass", {31'd0, bus.sldu_bypass_o}, {31'd0, mCfg.byp});
                end
            end
            if (bus.done_valid_o && !prevDone) begin
                if (doneQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedDone: got done at cycle %0d, expected none", cycle);
                end else begin
                    mDone = doneQ.pop_front();
                    checkOutput("doneCycle", cycle, mDone);
                end
            end
        end
        prevDone = bus.done_valid_o;
    end

    // Called at a negedge with the DUT idle; returns the acceptance cycle.
    task automatic applyStimulus(input logic dir, input int tx, input int rx, output int t);
        cfg_t c;
        checkOutput("reqReady", {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_dir_i      = dir;
        bus.req_tx_beats_i = CntW'(tx);
        bus.req_rx_beats_i = CntW'(rx);
        t     = cycle;
        c.cyc = t + 1;
        c.dir = dir;
        c.byp = (tx == 0) && (rx == 0);
        cfgQ.push_back(c);
        @(negedge clk_i);
        bus.req_valid_i    = 1'b0;
        bus.req_dir_i      = ~dir;
        bus.req_tx_beats_i = '1;
        bus.req_rx_beats_i = '1;
    endtask

    task automatic checkEnables(input string tag, input logic txExp, input logic rxExp);
        checkOutput({tag, "TxEn"}, {31'd0, bus.tx_en_o}, {31'd0, txExp});
        checkOutput({tag, "RxEn"}, {31'd0, bus.rx_en_o}, {31'd0, rxExp});
    endtask

    task automatic waitAndAckDone(input int hold);
        int n;
        n = 0;
        while (!bus.done_valid_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.done_valid_o) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL doneTimeout: got no done after %0d cycles, expected done", n);
            return;
        end
        repeat (hold) begin
            checkOutput("doneHeld", {31'd0, bus.done_valid_o}, 32'd1);
            checkOutput("readyBlocked", {31'd0, bus.req_ready_o}, 32'd0);
            @(negedge clk_i);
        end
        bus.done_ready_i = 1'b1;
        @(negedge clk_i);
        bus.done_ready_i = 1'b0;
        checkOutput("idleAfterDone", {31'd0, bus.req_ready_o}, 32'd1);
        checkOutput("doneDropped", {31'd0, bus.done_valid_o}, 32'd0);
        checkOutput("errState", {31'd0, bus.err_o}, {31'd0, expErr});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Ready"}, {31'd0, bus.req_ready_o}, 32'd1);
        checkOutput({tag, "Dir"}, {31'd0, bus.sldu_dir_o}, 32'd0);
        checkOutput({tag, "Bypass"}, {31'd0, bus.sldu_bypass_o}, 32'd1);
        checkOutput({tag, "Cfg"}, {31'd0, bus.sldu_config_valid_o}, 32'd0);
        checkEnables(tag, 1'b0, 1'b0);
        checkOutput({tag, "Done"}, {31'd0, bus.done_valid_o}, 32'd0);
        checkOutput({tag, "Err"}, {31'd0, bus.err_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        logic [8:0] pat;
        testsRun    = 0;
        testsFailed = 0;
        expErr      = 1'b0;
        prevDone    = 1'b0;
        rst_ni      = 1'b0;
        bus.req_valid_i    = 1'b0;
        bus.req_dir_i      = 1'b0;
        bus.req_tx_beats_i = '0;
        bus.req_rx_beats_i = '0;
        bus.tx_fire_i      = 1'b0;
        bus.rx_fire_i      = 1'b0;
        bus.done_ready_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        checkResetValues("rst");
        checkOutput("clusterId", {30'd0, bus.cluster_id_o}, ClusterId);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] basic transaction");
        applyStimulus(1'b1, 3, 3, t);
        doneQ.push_back(t + 7);
        checkEnables("cfg", 1'b0, 1'b0);
        @(negedge clk_i);
        for (int k = 0; k < 3; k++) begin
            checkEnables("basic", 1'b1, 1'b1);
            bus.tx_fire_i   = 1'b1;
            bus.rx_fire_i   = 1'b1;
            bus.req_valid_i = (k == 0);
            bus.req_tx_beats_i = '0;
            bus.req_rx_beats_i = '0;
            @(negedge clk_i);
        end
        bus.req_valid_i = 1'b0;
        bus.tx_fire_i   = 1'b0;
        bus.rx_fire_i   = 1'b0;
        checkEnables("basicEnd", 1'b0, 1'b0);
        checkOutput("basicErr", {31'd0, bus.err_o}, 32'd0);
        waitAndAckDone(0);

        $display("[TB] bypass transaction");
        applyStimulus(1'b0, 0, 0, t);
        doneQ.push_back(t + 4);
        repeat (3) begin
            checkEnables("bypass", 1'b0, 1'b0);
            @(negedge clk_i);
        end
        waitAndAckDone(0);

        $display("[TB] asymmetric counts");
        applyStimulus(1'b1, 5, 0, t);
        doneQ.push_back(t + 13);
        @(negedge clk_i);
        pat = 9'b101001101;
        for (int k = 0; k < 9; k++) begin
            checkEnables("asym", 1'b1, 1'b0);
            bus.tx_fire_i = pat[k];
            @(negedge clk_i);
        end
        checkEnables("asymEnd", 1'b0, 1'b0);
        checkOutput("asymErrClear", {31'd0, bus.err_o}, 32'd0);
        bus.tx_fire_i = 1'b1;
        @(negedge clk_i);
        bus.tx_fire_i = 1'b0;
        expErr = 1'b1;
        checkOutput("strayErr", {31'd0, bus.err_o}, 32'd1);
        waitAndAckDone(0);

        $display("[TB] done backpressure");
        applyStimulus(1'b1, 1, 1, t);
        doneQ.push_back(t + 5);
        @(negedge clk_i);
        checkEnables("bp", 1'b1, 1'b1);
        bus.tx_fire_i = 1'b1;
        bus.rx_fire_i = 1'b1;
        @(negedge clk_i);
        bus.tx_fire_i = 1'b0;
        bus.rx_fire_i = 1'b0;
        waitAndAckDone(10);
        applyStimulus(1'b0, 2, 0, t);
        doneQ.push_back(t + 6);
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            checkEnables("bp2", 1'b1, 1'b0);
            bus.tx_fire_i = 1'b1;
            @(negedge clk_i);
        end
        bus.tx_fire_i = 1'b0;
        checkEnables("bp2End", 1'b0, 1'b0);
        waitAndAckDone(0);

        $display("[TB] reset mid-transaction");
        applyStimulus(1'b1, 4, 4, t);
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            bus.tx_fire_i = 1'b1;
            bus.rx_fire_i = 1'b1;
            @(negedge clk_i);
        end
        bus.tx_fire_i = 1'b0;
        bus.rx_fire_i = 1'b0;
        rst_ni = 1'b0;
        expErr = 1'b0;
        #1;
        checkResetValues("midRst");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        applyStimulus(1'b0, 1, 2, t);
        doneQ.push_back(t + 6);
        @(negedge clk_i);
        checkEnables("post0", 1'b1, 1'b1);
        bus.tx_fire_i = 1'b1;
        bus.rx_fire_i = 1'b1;
        @(negedge clk_i);
        checkEnables("post1", 1'b0, 1'b1);
        bus.tx_fire_i = 1'b0;
        @(negedge clk_i);
        bus.rx_fire_i = 1'b0;
        checkEnables("post2", 1'b0, 1'b0);
        waitAndAckDone(0);

        $display("[TB] max count");
        applyStimulus(1'b1, MaxBeats, MaxBeats, t);
        doneQ.push_back(t + 2 + 2 * MaxBeats - 1 + 1 + SettleCycles);
        @(negedge clk_i);
        for (int k = 0; k < 2 * MaxBeats; k++) begin
            checkEnables("max", (k < 2 * MaxBeats - 1), 1'b1);
            bus.tx_fire_i = (k % 2 == 0) || (k == 2 * MaxBeats - 1);
            bus.rx_fire_i = (k % 2 == 1);
            @(negedge clk_i);
        end
        bus.tx_fire_i = 1'b0;
        bus.rx_fire_i = 1'b0;
        expErr = 1'b1;
        checkEnables("maxEnd", 1'b0, 1'b0);
        waitAndAckDone(0);

        repeat (5) @(negedge clk_i);
        checkOutput("cfgQueueDrained", cfgQ.size(), 32'd0);
        checkOutput("doneQueueDrained", doneQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
